reaction_ctrl: RTL and testbench



---
 rtl/reaction_pkg.sv | 25 ++
 rtl/ms_tick.sv | 36 +++
 rtl/reaction_ctrl.sv | 168 ++++++++++++++++
 tb/tb_reaction_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// reaction_pkg
//   Shared definitions for the reaction-time game round sequencer:
//   FSM state encoding, the time saturation value, and the LFSR seed,
//   tap mask and single-step function used for the random pre-GO delay.
package reaction_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_GO   = 3'd2,
        S_DONE = 3'd3,
        S_FOUL = 3'd4
    } state_t;

    localparam int MAX_MS = 9999;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/ms_tick.sv
// ms_tick
//   Free-running prescaler producing a one-cycle tick every DIV cycles.
//   A synchronous clear restarts the count so that the first tick after a
//   clear is seen DIV cycles later.
// Ports:
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset
//   clr    in  synchronous prescaler clear
//   tick   out high for one cycle when the prescaler reaches DIV-1
module ms_tick #(
    parameter int DIV = 50_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/reaction_ctrl.sv
// reaction_ctrl
//   Round sequencer for the reaction-time game. A start pulse launches a
//   pseudo-random wait, after which the GO LED lights and the reaction time
//   is counted in milliseconds until the button press. False starts and
//   timeouts are flagged, the best valid time is kept, and the release
//   detector enable is gated so each round needs one clean release.
// Configuration:
//   REACT_BEST_EN  when defined, best_ms tracks the minimum valid time;
//                  otherwise best_ms is tied to MAX_MS.
// Ports:
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   start        in   one-cycle pulse from the release detector
//   btn          in   synchronized button level, 1 = pressed
//   start_en     out  enable to the release detector
//   led          out  GO light
//   time_ms      out  last measured reaction time (ms)
//   best_ms      out  best valid time, MAX_MS when none yet
//   false_start  out  last round fouled
//   timeout      out  last round hit MAX_MS
//   busy         out  round in progress (WAIT or GO)
module reaction_ctrl
    import reaction_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    parameter int TIME_W       = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              btn,
    output logic              start_en,
    output logic              led,
    output logic [TIME_W-1:0] time_ms,
    output logic [TIME_W-1:0] best_ms,
    output logic              false_start,
    output logic              timeout,
    output logic              busy
);

    localparam int                TICK_DIV = CLK_HZ / 1000;
    localparam int                DLY_W    = $clog2(MIN_DELAY_MS + (1 << RAND_BITS));
    localparam logic [TIME_W-1:0] MAX_T    = TIME_W'(MAX_MS);
    localparam logic [TIME_W-1:0] MAX_T_M1 = TIME_W'(MAX_MS - 1);

    state_t           state, state_nx;
    logic [15:0]      lfsr;
    logic [DLY_W-1:0] delay_cnt;
    logic             armed, armed_nx;
    logic             led_nx, busy_nx, start_en_nx;
    logic             tick, tick_clr, round_end, saturate;

    ms_tick #(.DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr),
        .tick  (tick)
    );

    assign saturate = tick && (time_ms == MAX_T_M1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // A press always beats the coincident final WAIT tick or saturating GO tick.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE, S_DONE, S_FOUL: begin
                if (start) state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (btn)                                     state_nx = S_FOUL;
                else if (tick && delay_cnt == DLY_W'(1))     state_nx = S_GO;
            end
            S_GO: begin
                if (btn || saturate) state_nx = S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Next values of the registered outputs are decoded from the next state.
    // Entry to DONE/FOUL disarms even if btn is already low that cycle; the
    // following cycle with btn=0 re-arms.
    always_comb begin
        round_end   = (state == S_GO && state_nx == S_DONE) ||
                      (state == S_WAIT && state_nx == S_FOUL);
        tick_clr    = (state_nx == S_WAIT && state != S_WAIT) ||
                      (state_nx == S_GO && state != S_GO);
        led_nx      = (state_nx == S_GO);
        busy_nx     = (state_nx == S_WAIT) || (state_nx == S_GO);
        armed_nx    = armed;
        if (round_end)  armed_nx = 1'b0;
        else if (!btn)  armed_nx = 1'b1;
        start_en_nx = armed_nx && !busy_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr        <= LFSR_SEED;
            led         <= 1'b0;
            busy        <= 1'b0;
            start_en    <= 1'b1;
            armed       <= 1'b1;
            time_ms     <= '0;
            false_start <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            lfsr     <= lfsr_step(lfsr);
            led      <= led_nx;
            busy     <= busy_nx;
            start_en <= start_en_nx;
            armed    <= armed_nx;
            unique case (state)
                S_IDLE, S_DONE, S_FOUL: begin
                    if (start) begin
                        time_ms     <= '0;
                        false_start <= 1'b0;
                        timeout     <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (btn) false_start <= 1'b1;
                end
                S_GO: begin
                    if (tick)              time_ms <= time_ms + 1'b1;
                    if (saturate && !btn)  timeout <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Delay counter is loaded before every use, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state != S_WAIT && state != S_GO && start) begin
            delay_cnt <= DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr[RAND_BITS-1:0]);
        end else if (state == S_WAIT && tick) begin
            delay_cnt <= delay_cnt - 1'b1;
        end
    end

`ifdef REACT_BEST_EN
    // Time as it will stand after this edge, including a coincident tick.
    logic [TIME_W-1:0] time_fin;
    assign time_fin = tick ? time_ms + 1'b1 : time_ms;

    // A GO->DONE caused by the press is the only non-timeout round end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            best_ms <= MAX_T;
        end else if (state == S_GO && btn && time_fin < best_ms) begin
            best_ms <= time_fin;
        end
    end
`else
    assign best_ms = MAX_T;
`endif

endmodule

// File: tb/tb_reaction_ctrl.sv
module tb_reaction_ctrl;

    localparam int MAXV = 9999;

    typedef struct {
        int press;
        int exp_time;
        int exp_best;
    } round_t;

    round_t tbl [5];
    int     checks = 0;
    int     errors = 0;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic sel     = 1'b0;
    logic start_r = 1'b0;
    logic btn_r   = 1'b0;

    logic start_a, btn_a, start_b, btn_b;
    logic sen_a, led_a, fs_a, to_a, busy_a;
    logic sen_b, led_b, fs_b, to_b, busy_b;
    logic [13:0] tm_a, best_a, tm_b, best_b;

    logic m_led, m_busy, m_sen, m_fs, m_to;
    logic [13:0] m_time, m_best;
    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    assign start_a = start_r & ~sel;
    assign btn_a   = btn_r & ~sel;
    assign start_b = start_r & sel;
    assign btn_b   = btn_r & sel;

    always_comb begin
        m_led  = sel ? led_b  : led_a;
        m_busy = sel ? busy_b : busy_a;
        m_sen  = sel ? sen_b  : sen_a;
        m_fs   = sel ? fs_b   : fs_a;
        m_to   = sel ? to_b   : to_a;
        m_time = sel ? tm_b   : tm_a;
        m_best = sel ? best_b : best_a;
    end

    // Reference LFSR: 16-bit Galois, x^16+x^14+x^13+x^11, seed ACE1.
    always @(posedge clk) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    // 1 ms = 4 cycles
    reaction_ctrl #(.CLK_HZ(4000), .MIN_DELAY_MS(3), .RAND_BITS(2), .TIME_W(14)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .btn(btn_a),
        .start_en(sen_a), .led(led_a), .time_ms(tm_a), .best_ms(best_a),
        .false_start(fs_a), .timeout(to_a), .busy(busy_a)
    );

    // 1 ms = 1 cycle, for the long saturation rounds
    reaction_ctrl #(.CLK_HZ(1000), .MIN_DELAY_MS(3), .RAND_BITS(2), .TIME_W(14)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .btn(btn_b),
        .start_en(sen_b), .led(led_b), .time_ms(tm_b), .best_ms(best_b),
        .false_start(fs_b), .timeout(to_b), .busy(busy_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int bexp(input int v);
`ifdef REACT_BEST_EN
        return v;
`else
        return MAXV + 0 * v;
`endif
    endfunction

    // Pulse start and wait for the GO light; returns at the negedge right after the rise.
    task automatic launch();
        int exp_lat;
        int lat;
        @(negedge clk);
        exp_lat = (3 + int'(m_lfsr[1:0])) * (sel ? 1 : 4);
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        chk("wait_busy", 32'(m_busy), 1);
        chk("wait_led", 32'(m_led), 0);
        chk("wait_time_clr", 32'(m_time), 0);
        chk("wait_flags_clr", {30'd0, m_fs, m_to}, 0);
        lat = 0;
        while (!m_led && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("led_rise_lat", lat, exp_lat);
    endtask

    // btn is sampled k edges after the led rise edge.
    task automatic press_after(input int k);
        repeat (k - 1) @(negedge clk);
        btn_r = 1'b1;
        @(negedge clk);
    endtask

    task automatic hold_release(input string nm);
        repeat (2) @(negedge clk);
        chk({nm, "_sen_held"}, 32'(m_sen), 0);
        btn_r = 1'b0;
        @(negedge clk);
        chk({nm, "_sen_rearm"}, 32'(m_sen), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_lat;
        int j;
        int led_seen;

        tbl[0] = '{press: 21, exp_time: 5,  exp_best: 5};
        tbl[1] = '{press: 29, exp_time: 7,  exp_best: 5};
        tbl[2] = '{press: 12, exp_time: 3,  exp_best: 3};
        tbl[3] = '{press: 5,  exp_time: 1,  exp_best: 1};
        tbl[4] = '{press: 40, exp_time: 10, exp_best: 1};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_led", 32'(led_a), 0);
        chk("rst_time", 32'(tm_a), 0);
        chk("rst_best", 32'(best_a), MAXV);
        chk("rst_sen", 32'(sen_a), 1);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_flags", {30'd0, fs_a, to_a}, 0);
        chk("rst_b_best", 32'(best_b), MAXV);
        rst_n = 1'b1;

        // normal rounds from the table
        sel = 1'b0;
        for (int i = 0; i < 5; i++) begin
            launch();
            press_after(tbl[i].press);
            chk($sformatf("rnd%0d_time", i), 32'(m_time), tbl[i].exp_time);
            chk($sformatf("rnd%0d_best", i), 32'(m_best), bexp(tbl[i].exp_best));
            chk($sformatf("rnd%0d_led", i), 32'(m_led), 0);
            chk($sformatf("rnd%0d_busy", i), 32'(m_busy), 0);
            chk($sformatf("rnd%0d_flags", i), {30'd0, m_fs, m_to}, 0);
            chk($sformatf("rnd%0d_sen", i), 32'(m_sen), 0);
            hold_release($sformatf("rnd%0d", i));
        end

        // false start during WAIT
        @(negedge clk);
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        repeat (3) @(negedge clk);
        btn_r = 1'b1;
        @(negedge clk);
        chk("foul_fs", 32'(m_fs), 1);
        chk("foul_led", 32'(m_led), 0);
        chk("foul_busy", 32'(m_busy), 0);
        chk("foul_time", 32'(m_time), 0);
        chk("foul_best", 32'(m_best), bexp(1));
        chk("foul_sen", 32'(m_sen), 0);
        hold_release("foul");

        // btn on the final WAIT tick: foul wins, no GO
        @(negedge clk);
        exp_lat = (3 + int'(m_lfsr[1:0])) * 4;
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        repeat (exp_lat - 1) @(negedge clk);
        btn_r = 1'b1;
        @(negedge clk);
        chk("lasttick_fs", 32'(m_fs), 1);
        chk("lasttick_led", 32'(m_led), 0);
        chk("lasttick_busy", 32'(m_busy), 0);
        led_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (m_led) led_seen++;
        end
        chk("lasttick_no_go", led_seen, 0);
        chk("lasttick_best", 32'(m_best), bexp(1));
        btn_r = 1'b0;
        @(negedge clk);
        chk("lasttick_sen", 32'(m_sen), 1);

        // 1-cycle-ms instance: a valid round to seed best, then timeout and saturating press
        sel = 1'b1;
        launch();
        press_after(7);
        chk("b_time", 32'(m_time), 7);
        chk("b_best", 32'(m_best), bexp(7));
        hold_release("b");

        launch();
        j = 0;
        while (m_busy && j < 10100) begin
            @(negedge clk);
            j++;
        end
        chk("to_cycles", j, MAXV);
        chk("to_time", 32'(m_time), MAXV);
        chk("to_flag", 32'(m_to), 1);
        chk("to_led", 32'(m_led), 0);
        chk("to_fs", 32'(m_fs), 0);
        chk("to_best", 32'(m_best), bexp(7));
        repeat (2) @(negedge clk);
        chk("to_sen", 32'(m_sen), 1);

        launch();
        press_after(MAXV);
        chk("sat_time", 32'(m_time), MAXV);
        chk("sat_to", 32'(m_to), 0);
        chk("sat_led", 32'(m_led), 0);
        chk("sat_busy", 32'(m_busy), 0);
        chk("sat_best", 32'(m_best), bexp(7));
        btn_r = 1'b0;
        @(negedge clk);

        // reset in the middle of a WAIT
        sel = 1'b0;
        @(negedge clk);
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy_pre", 32'(m_busy), 1);
        chk("mid_best_pre", 32'(m_best), bexp(1));
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mid_best", 32'(m_best), MAXV);
        chk("mid_busy", 32'(m_busy), 0);
        chk("mid_led", 32'(m_led), 0);
        chk("mid_sen", 32'(m_sen), 1);
        chk("mid_time", 32'(m_time), 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
